// File: rtl/otter_mem_responder.sv
// Word-organised on-chip RAM target for the OTTER memory request interface.
// Handles byte/half/word accesses with lane writes, load extension and fault reporting.
module otter_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        sign,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        error
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RDATA = 2'b01,
    WDONE = 2'b10,
    FAULT = 2'b11
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [31:0]    rel_addr_s;
  logic [AW-1:0]  word_idx_s;
  logic           accept_s;
  logic           fault_s;
  logic           wr_ok_s;
  logic [3:0]     be_s;
  logic [31:0]    wdata_s;
  logic [31:0]    mem_r [DEPTH_WORDS];
  logic [31:0]    rword_r;
  logic [1:0]     off_r;
  logic [1:0]     size_r;
  logic           sign_r;
  logic           error_r;
  logic [31:0]    shifted_s;

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
  assign rel_addr_s = addr - BASE_ADDR;
  assign word_idx_s = rel_addr_s[AW+1:2];
  assign accept_s   = memRead | memWrite;
  assign wr_ok_s    = ~rst & memWrite & ~fault_s;

  // Request legality classification.
  always_comb begin
    fault_s = 1'b0;
    if (memRead && memWrite) begin
      fault_s = 1'b1;
    end else if (size == 2'b11) begin
      fault_s = 1'b1;
    end else if ((size == 2'b01) && addr[0]) begin
      fault_s = 1'b1;
    end else if ((size == 2'b10) && (addr[1:0] != 2'b00)) begin
      fault_s = 1'b1;
    end else if ({1'b0, rel_addr_s} >= MEM_BYTES) begin
      fault_s = 1'b1;
    end else begin
      fault_s = 1'b0;
    end
  end

  // Byte-lane enables and lane-replicated write data.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = data_out;
    case (size)
      2'b00: begin
        be_s    = 4'b0001 << addr[1:0];
        wdata_s = {4{data_out[7:0]}};
      end
      2'b01: begin
        be_s    = 4'b0011 << addr[1:0];
        wdata_s = {2{data_out[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b1111;
        wdata_s = data_out;
      end
      default: begin
        be_s    = 4'b0000;
        wdata_s = data_out;
      end
    endcase
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  // Read capture; a faulting read loads a zero word so extraction yields 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rword_r <= 32'h0000_0000;
      off_r   <= 2'b00;
      size_r  <= 2'b10;
      sign_r  <= 1'b0;
    end else if (accept_s && memRead) begin
      if (fault_s) begin
        rword_r <= 32'h0000_0000;
        off_r   <= 2'b00;
        size_r  <= 2'b10;
        sign_r  <= 1'b0;
      end else begin
        rword_r <= mem_r[word_idx_s];
        off_r   <= addr[1:0];
        size_r  <= size;
        sign_r  <= sign;
      end
    end
  end

  // State and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      error_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        error_r <= fault_s;
      end
    end
  end

  // Next state from the classification of the accepted request.
  always_comb begin
    next_state_s = state_r;
    if (accept_s) begin
      if (fault_s) begin
        next_state_s = FAULT;
      end else if (memRead) begin
        next_state_s = RDATA;
      end else begin
        next_state_s = WDONE;
      end
    end else begin
      next_state_s = state_r;
    end
  end

  assign shifted_s = rword_r >> {off_r, 3'b000};

  // Load extraction from the captured word (sign=1 selects zero extension).
  always_comb begin
    data_in = rword_r;
    case (size_r)
      2'b00: begin
        data_in = sign_r ? {24'h00_0000, shifted_s[7:0]}
                         : {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      2'b01: begin
        data_in = sign_r ? {16'h0000, shifted_s[15:0]}
                         : {{16{shifted_s[15]}}, shifted_s[15:0]};
      end
      2'b10: begin
        data_in = rword_r;
      end
      default: begin
        data_in = rword_r;
      end
    endcase
  end

  assign error = error_r;

endmodule

// File: tb/tb_otter_mem_responder.sv
// Randomised self-checking bench for otter_mem_responder against a byte-array model.
module tb_otter_mem_responder;

  localparam int unsigned DEPTH     = 256;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          MEM_BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead;
  logic        memWrite;
  logic        sign;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        error;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] exp_data;
  logic        exp_err;

  otter_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .sign(sign), .size(size), .addr(addr), .data_out(data_out),
    .data_in(data_in), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: byte-addressed memory, faults from the request rules.
  task automatic model_apply(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sg, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    logic [31:0] v;
    logic        flt;
    int          n;
    off = a - BASE;
    flt = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 2'b00) || (off >= 32'(MEM_BYTES));
    if (!rd && !wr) return;
    exp_err = flt;
    n = 1 << sz;
    if (flt) begin
      if (rd) exp_data = 32'h0;
    end else if (wr) begin
      for (int k = 0; k < n; k++) ref_mem[int'(off) + k] = d[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(off) + k]) << (8*k));
      if (sz == 2'b10)      exp_data = v;
      else if (sz == 2'b01) exp_data = sg ? v : {{16{v[15]}}, v[15:0]};
      else                  exp_data = sg ? v : {{24{v[7]}}, v[7:0]};
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] a, input logic [31:0] d);
    memRead = rd; memWrite = wr; size = sz; sign = sg; addr = a; data_out = d;
    @(posedge clk);
    model_apply(rd, wr, sz, sg, a, d);
    #1;
    check("data_in", data_in, exp_data);
    check("error", {31'h0, error}, {31'h0, exp_err});
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; sign = 1'b0;
    size = 2'b00; addr = 32'h0; data_out = 32'h0;
    exp_data = 32'h0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data_in, 32'h0);
    check("reset_err", {31'h0, error}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) req(1'b0, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

    // Word write then read.
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("tp_word", data_in, 32'hDEAD_BEEF);

    // Sub-word loads.
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h807F_01FF);
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    check("tp_lb", data_in, 32'hFFFF_FFFF);
    req(1'b1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    check("tp_lbu", data_in, 32'h0000_00FF);
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    check("tp_lh", data_in, 32'hFFFF_807F);
    req(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    check("tp_lhu", data_in, 32'h0000_807F);

    // Byte-lane writes.
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h1122_3344);
    req(1'b0, 1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFF_FFAA);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("tp_sb", data_in, 32'h1122_AA44);
    req(1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF_5566);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("tp_sh", data_in, 32'h5566_AA44);

    // Faults, each followed by a legal read that clears error.
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h31, 32'h0);
    check("tp_f_misword", {31'h0, error}, 32'h1);
    check("tp_f_misword_data", data_in, 32'h0);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("tp_f_clear", {31'h0, error}, 32'h0);
    req(1'b0, 1'b1, 2'b01, 1'b0, 32'h33, 32'h0000_9999);
    check("tp_f_mishalf", {31'h0, error}, 32'h1);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("tp_f_mishalf_ram", data_in, 32'h5566_AA44);
    req(1'b1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0);
    check("tp_f_size3", {31'h0, error}, 32'h1);
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0);
    check("tp_f_both", {31'h0, error}, 32'h1);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("tp_f_both_ram", data_in, 32'h5566_AA44);
    req(1'b1, 1'b0, 2'b10, 1'b0, BASE + 32'(MEM_BYTES), 32'h0);
    check("tp_f_range", {31'h0, error}, 32'h1);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    // Reset on the same edge as a write.
    rst = 1'b1; memRead = 1'b0; memWrite = 1'b1; size = 2'b10;
    addr = 32'h40; data_out = 32'h1234_5678;
    @(posedge clk);
    exp_data = 32'h0; exp_err = 1'b0;
    #1;
    check("rst_data", data_in, 32'h0);
    check("rst_err", {31'h0, error}, 32'h0);
    rst = 1'b0;
    idle();
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);

    // Back-to-back reads.
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("b2b_0", data_in, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check("b2b_1", data_in, 32'h807F_01FF);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("b2b_2", data_in, 32'h5566_AA44);
    repeat (3) idle();

    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 9);
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      if ($urandom_range(0, 19) == 0) a = $urandom;
      if (r == 0)      idle();
      else if (r == 1) req(1'b1, 1'b1, sz, 1'($urandom), a, $urandom);
      else if (r < 6)  req(1'b1, 1'b0, sz, 1'($urandom), a, 32'h0);
      else             req(1'b0, 1'b1, sz, 1'b0, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
